// File: rtl/sprite_line_scheduler_if.sv
// sprite_line_scheduler_if: video timing, sprite-table write port, sprite ROM port and composited
// pixel outputs. The scheduler sits on the slave modport; video timing/CPU/ROM sit on master.
interface sprite_line_scheduler_if #(
    parameter int ROM_AW = 11
);
    // spr_we is a one-clk write strobe that is always accepted (no ready), and rom_addr carries no
    // valid/ready: the ROM answers every presented address with rom_data exactly one clk later.
    logic              pix_en;
    logic [9:0]        hcount;
    logic [9:0]        vcount;
    logic              spr_we;
    logic [2:0]        spr_wsel;
    logic              spr_wen;
    logic [9:0]        spr_whpos;
    logic [9:0]        spr_wvpos;
    logic [8:0]        spr_whoff;
    logic [8:0]        spr_wvoff;
    logic              spr_wflip;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              spr_hit;
    logic [7:0]        spr_rgb;
    logic              busy;
    logic              line_ovf;
    logic              late;
    logic [1:0]        dbg_state;

    modport master (
        output pix_en, hcount, vcount, spr_we, spr_wsel, spr_wen, spr_whpos, spr_wvpos,
               spr_whoff, spr_wvoff, spr_wflip, rom_data,
        input  rom_addr, spr_hit, spr_rgb, busy, line_ovf, late, dbg_state
    );

    modport slave (
        input  pix_en, hcount, vcount, spr_we, spr_wsel, spr_wen, spr_whpos, spr_wvpos,
               spr_whoff, spr_wvoff, spr_wflip, rom_data,
        output rom_addr, spr_hit, spr_rgb, busy, line_ovf, late, dbg_state
    );
endinterface

// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: per-line sprite table scan, shadow-slot ROM fetch, line-end swap and
// per-pixel compositing. Define SPRITE_HFLIP_EN to build horizontal mirroring.
module sprite_line_scheduler #(
    parameter int N_SPR   = 6,
    parameter int SLOTS   = 4,
    parameter int SPR_W   = 16,
    parameter int SHEET_W = 48,
    parameter int ROM_AW  = 11,
    parameter int HTOTAL  = 800,
    parameter int VTOTAL  = 521,
    parameter int FETCH_H = 0
) (
    input logic clk,
    input logic rst,
    sprite_line_scheduler_if.slave bus
);
    localparam int IW = (N_SPR > 1) ? $clog2(N_SPR) : 1;
    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CW = $clog2(SPR_W);
    localparam int NW = $clog2(SLOTS + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, FETCH = 2'd2} state_t;

    state_t            state;
    logic [N_SPR-1:0]  t_en;
    logic [9:0]        t_hpos [N_SPR];
    logic [9:0]        t_vpos [N_SPR];
    logic [8:0]        t_hoff [N_SPR];
    logic [8:0]        t_voff [N_SPR];
    logic [SLOTS-1:0]  sh_valid, act_valid;
    logic [9:0]        sh_hpos [SLOTS];
    logic [9:0]        act_hpos [SLOTS];
    logic [CW-1:0]     sh_row [SLOTS];
    logic [8:0]        sh_hoff [SLOTS];
    logic [8:0]        sh_voff [SLOTS];
    logic [7:0]        sh_pix [SLOTS][SPR_W];
    logic [7:0]        act_pix [SLOTS][SPR_W];
`ifdef SPRITE_HFLIP_EN
    logic [N_SPR-1:0]  t_flip;
    logic [SLOTS-1:0]  sh_flip, act_flip;
`endif
    logic [IW-1:0]     scan_idx;
    logic [9:0]        tgt_line;
    logic [NW-1:0]     n_fill;
    logic              ovf_seen, discard, issuing;
    logic [SW-1:0]     f_slot, p1_slot, p2_slot;
    logic [CW-1:0]     f_col, p1_col, p2_col;
    logic              p1_v, p2_v;
    logic [ROM_AW-1:0] rom_addr_q;
    logic              hit_q, ovf_q, late_q;
    logic [7:0]        rgb_q;

    logic [9:0]    scan_row, f_rv, px_d;
    logic          scan_vis, scan_room, scan_take, scan_last, last_col, last_slot;
    logic          swap_now, late_now, px_hit;
    logic [16:0]   addr_full;
    logic [CW-1:0] px_col;
    logic [7:0]    px_pix, px_rgb;

    assign scan_row  = tgt_line - t_vpos[scan_idx];
    assign scan_vis  = t_en[scan_idx] && (scan_row < 10'(SPR_W));
    assign scan_room = n_fill < NW'(SLOTS);
    assign scan_take = scan_vis && scan_room;
    assign scan_last = scan_idx == IW'(N_SPR - 1);
    assign f_rv      = 10'(sh_row[f_slot]) + 10'(sh_voff[f_slot]);
    assign addr_full = 17'(f_rv) * 17'(SHEET_W) + 17'(sh_hoff[f_slot]) + 17'(f_col);
    assign last_col  = f_col == CW'(SPR_W - 1);
    assign last_slot = (NW'(f_slot) + NW'(1)) == n_fill;
    assign swap_now  = bus.pix_en && (bus.hcount == 10'(HTOTAL - 1));
    assign late_now  = swap_now && (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_en <= '0;
`ifdef SPRITE_HFLIP_EN
            t_flip <= '0;
`endif
            for (int i = 0; i < N_SPR; i++) begin
                t_hpos[i] <= '0;
                t_vpos[i] <= '0;
                t_hoff[i] <= '0;
                t_voff[i] <= '0;
            end
        end else if (bus.spr_we && (int'(bus.spr_wsel) < N_SPR)) begin
            t_en[bus.spr_wsel]   <= bus.spr_wen;
            t_hpos[bus.spr_wsel] <= bus.spr_whpos;
            t_vpos[bus.spr_wsel] <= bus.spr_wvpos;
            t_hoff[bus.spr_wsel] <= bus.spr_whoff;
            t_voff[bus.spr_wsel] <= bus.spr_wvoff;
`ifdef SPRITE_HFLIP_EN
            t_flip[bus.spr_wsel] <= bus.spr_wflip;
`endif
        end
    end

    // Lowest slot wins: walk from the highest slot down so lower slots overwrite.
    always_comb begin
        px_hit = 1'b0;
        px_rgb = 8'h00;
        px_d   = '0;
        px_col = '0;
        px_pix = 8'h00;
        for (int s = SLOTS - 1; s >= 0; s--) begin
            px_d   = bus.hcount - act_hpos[s];
            px_col = CW'(px_d - 10'd1);
`ifdef SPRITE_HFLIP_EN
            if (act_flip[s]) px_col = CW'(SPR_W - 1) - px_col;
`endif
            px_pix = act_pix[s][px_col];
            if (act_valid[s] && (px_d != 10'd0) && (px_d <= 10'(SPR_W)) && (px_pix != 8'hFF)) begin
                px_hit = 1'b1;
                px_rgb = px_pix;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            scan_idx <= '0; tgt_line <= '0; n_fill <= '0;
            ovf_seen <= 1'b0; discard <= 1'b0; issuing <= 1'b0;
            f_slot <= '0; f_col <= '0;
            p1_v <= 1'b0; p1_slot <= '0; p1_col <= '0;
            p2_v <= 1'b0; p2_slot <= '0; p2_col <= '0;
            rom_addr_q <= '0; hit_q <= 1'b0; rgb_q <= 8'h00; ovf_q <= 1'b0; late_q <= 1'b0;
            sh_valid <= '0; act_valid <= '0;
`ifdef SPRITE_HFLIP_EN
            sh_flip <= '0; act_flip <= '0;
`endif
            for (int s = 0; s < SLOTS; s++) begin
                sh_hpos[s] <= '0; act_hpos[s] <= '0;
                sh_row[s] <= '0; sh_hoff[s] <= '0; sh_voff[s] <= '0;
                for (int c = 0; c < SPR_W; c++) begin
                    sh_pix[s][c]  <= 8'h00;
                    act_pix[s][c] <= 8'h00;
                end
            end
        end else begin
            ovf_q      <= 1'b0;
            late_q     <= 1'b0;
            p1_v       <= 1'b0;
            rom_addr_q <= '0;
            p2_v       <= p1_v;
            p2_slot    <= p1_slot;
            p2_col     <= p1_col;
            if (p2_v) sh_pix[p2_slot][p2_col] <= bus.rom_data;

            case (state)
                IDLE: begin
                    if (bus.pix_en && (bus.hcount == 10'(FETCH_H))) begin
                        state    <= SCAN;
                        tgt_line <= (bus.vcount == 10'(VTOTAL - 1)) ? 10'd0 : bus.vcount + 10'd1;
                        scan_idx <= '0;
                        n_fill   <= '0;
                        ovf_seen <= 1'b0;
                        discard  <= 1'b0;
                        sh_valid <= '0;
                    end
                end
                SCAN: begin
                    if (scan_take) begin
                        sh_valid[SW'(n_fill)] <= 1'b1;
                        sh_hpos[SW'(n_fill)]  <= t_hpos[scan_idx];
                        sh_row[SW'(n_fill)]   <= CW'(scan_row);
                        sh_hoff[SW'(n_fill)]  <= t_hoff[scan_idx];
                        sh_voff[SW'(n_fill)]  <= t_voff[scan_idx];
`ifdef SPRITE_HFLIP_EN
                        sh_flip[SW'(n_fill)]  <= t_flip[scan_idx];
`endif
                        n_fill <= n_fill + NW'(1);
                    end else if (scan_vis) begin
                        ovf_seen <= 1'b1;
                    end
                    if (scan_last) begin
                        ovf_q   <= ovf_seen || (scan_vis && !scan_room);
                        f_slot  <= '0;
                        f_col   <= '0;
                        issuing <= (n_fill != '0) || scan_take;
                        state   <= ((n_fill != '0) || scan_take) ? FETCH : IDLE;
                    end else begin
                        scan_idx <= scan_idx + IW'(1);
                    end
                end
                FETCH: begin
                    if (issuing) begin
                        rom_addr_q <= addr_full[ROM_AW-1:0];
                        p1_v       <= 1'b1;
                        p1_slot    <= f_slot;
                        p1_col     <= f_col;
                        f_col      <= f_col + CW'(1);
                        if (last_col) begin
                            if (last_slot) issuing <= 1'b0;
                            else f_slot <= f_slot + SW'(1);
                        end
                    end else if (!p1_v) begin
                        // Last capture lands on this edge; a late swap voids the whole line.
                        state <= IDLE;
                        if (discard || late_now) sh_valid <= '0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (swap_now) begin
                if (state != IDLE) begin
                    late_q    <= 1'b1;
                    discard   <= 1'b1;
                    act_valid <= '0;
                end else begin
                    act_valid <= sh_valid;
                    act_hpos  <= sh_hpos;
                    act_pix   <= sh_pix;
`ifdef SPRITE_HFLIP_EN
                    act_flip  <= sh_flip;
`endif
                end
            end

            if (bus.pix_en) begin
                hit_q <= px_hit;
                rgb_q <= px_rgb;
            end
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.spr_hit   = hit_q;
    assign bus.spr_rgb   = rgb_q;
    assign bus.busy      = (state != IDLE);
    assign bus.line_ovf  = ovf_q;
    assign bus.late      = late_q;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// tb_sprite_line_scheduler: directed line-by-line checks of the sprite scheduler, plus a second
// instance with FETCH_H=790 that overruns its fetch budget.
module tb_sprite_line_scheduler;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sprite_line_scheduler_if bus ();
    sprite_line_scheduler_if bus2 ();

    sprite_line_scheduler u_dut (.clk(clk), .rst(rst), .bus(bus.slave));
    sprite_line_scheduler #(.FETCH_H(790)) u_dut_late (.clk(clk), .rst(rst), .bus(bus2.slave));

    assign bus2.pix_en    = bus.pix_en;
    assign bus2.hcount    = bus.hcount;
    assign bus2.vcount    = bus.vcount;
    assign bus2.spr_we    = bus.spr_we;
    assign bus2.spr_wsel  = bus.spr_wsel;
    assign bus2.spr_wen   = bus.spr_wen;
    assign bus2.spr_whpos = bus.spr_whpos;
    assign bus2.spr_wvpos = bus.spr_wvpos;
    assign bus2.spr_whoff = bus.spr_whoff;
    assign bus2.spr_wvoff = bus.spr_wvoff;
    assign bus2.spr_wflip = bus.spr_wflip;

    // sprite-sheet ROM: synchronous, data one clk after the address
    logic [7:0] rom_mem [2048];
    always @(posedge clk) begin
        bus.rom_data  <= rom_mem[bus.rom_addr];
        bus2.rom_data <= rom_mem[bus2.rom_addr];
    end

    int ovf_cnt = 0, late_cnt = 0, late2_cnt = 0, busy_cnt = 0, late2_h = -1;
    always @(negedge clk) begin
        if (bus.line_ovf) ovf_cnt++;
        if (bus.late) late_cnt++;
        if (bus.busy) busy_cnt++;
        if (bus2.late) begin
            late2_cnt++;
            late2_h = int'(bus2.hcount);
        end
    end

    int total = 0, bad = 0;
    logic       cap_hit  [800];
    logic [7:0] cap_rgb  [800];
    logic       cap2_hit [800];

    typedef struct {
        int         h;
        logic       hit;
        logic [7:0] rgb;
    } pix_vec_t;
    pix_vec_t   vt[$];
    logic [8:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input int h, input logic hit, input logic [7:0] rgb);
        pix_vec_t v;
        v.h = h; v.hit = hit; v.rgb = rgb;
        vt.push_back(v);
    endtask

    task automatic check_vecs(input string tag);
        foreach (vt[i]) begin
            check($sformatf("%s h=%0d hit", tag, vt[i].h), 32'(cap_hit[vt[i].h]), 32'(vt[i].hit));
            check($sformatf("%s h=%0d rgb", tag, vt[i].h), 32'(cap_rgb[vt[i].h]), 32'(vt[i].rgb));
        end
        vt.delete();
    endtask

    task automatic write_entry(input int sel, input logic en, input int hp, input int vp,
                               input int ho, input int vo, input logic fl);
        @(negedge clk);
        bus.spr_we    = 1'b1;
        bus.spr_wsel  = 3'(sel);
        bus.spr_wen   = en;
        bus.spr_whpos = 10'(hp);
        bus.spr_wvpos = 10'(vp);
        bus.spr_whoff = 9'(ho);
        bus.spr_wvoff = 9'(vo);
        bus.spr_wflip = fl;
        @(negedge clk);
        bus.spr_we = 1'b0;
    endtask

    // One full scanline: pix_en every 4th clk, output of pixel h sampled one negedge after its edge.
    task automatic run_line(input int v);
        for (int h = 0; h < 800; h++) begin
            for (int p = 0; p < 4; p++) begin
                @(negedge clk);
                if (p == 1) begin
                    cap_hit[h]  = bus.spr_hit;
                    cap_rgb[h]  = bus.spr_rgb;
                    cap2_hit[h] = bus2.spr_hit;
                end
                bus.pix_en = (p == 0);
                bus.hcount = 10'(h);
                bus.vcount = 10'(v);
            end
        end
    endtask

    function automatic int count_hits(input int which);
        int n = 0;
        for (int h = 0; h < 800; h++) n += (which == 0) ? int'(cap_hit[h]) : int'(cap2_hit[h]);
        return n;
    endfunction

    int ovf0, late0, late20, busy0, c;
    logic [7:0] e;

    initial begin
        for (int a = 0; a < 2048; a++) rom_mem[a] = 8'(a);
        bus.pix_en = 1'b0; bus.hcount = '0; bus.vcount = '0;
        bus.spr_we = 1'b0; bus.spr_wsel = '0; bus.spr_wen = 1'b0; bus.spr_whpos = '0;
        bus.spr_wvpos = '0; bus.spr_whoff = '0; bus.spr_wvoff = '0; bus.spr_wflip = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset spr_hit", 32'(bus.spr_hit), 0);
        check("reset spr_rgb", 32'(bus.spr_rgb), 0);
        check("reset busy", 32'(bus.busy), 0);
        check("reset rom_addr", 32'(bus.rom_addr), 0);
        check("reset line_ovf", 32'(bus.line_ovf), 0);
        check("reset late", 32'(bus.late), 0);
        check("reset state", 32'(bus.dbg_state), 0);
        rst = 1'b0;

        // single sprite, flip bit set (mirrored only when the option is built), plus an out-of-range write
        write_entry(0, 1'b1, 200, 100, 16, 0, 1'b1);
        write_entry(6, 1'b1, 500, 100, 0, 0, 1'b0);
        ovf0 = ovf_cnt; busy0 = busy_cnt;
        run_line(99);
        check("t1 ovf count", 32'(ovf_cnt - ovf0), 0);
        check("t1 busy in budget", 32'((busy_cnt - busy0 >= 22) && (busy_cnt - busy0 <= 76)), 1);
        check("t1 line99 empty", 32'(count_hits(0)), 0);
        run_line(100);
        add_vec(200, 1'b0, 8'h00);
        for (int col = 0; col < 16; col++) begin
`ifdef SPRITE_HFLIP_EN
            add_vec(201 + col, 1'b1, 8'(16 + 15 - col));
`else
            add_vec(201 + col, 1'b1, 8'(16 + col));
`endif
        end
        add_vec(217, 1'b0, 8'h00);
        add_vec(501, 1'b0, 8'h00);
        add_vec(508, 1'b0, 8'h00);
        check_vecs("t1");

        // vertical wrap: line 520 fetches line 0
        write_entry(0, 1'b1, 400, 0, 16, 0, 1'b0);
        run_line(520);
        run_line(0);
        add_vec(400, 1'b0, 8'h00);
        add_vec(401, 1'b1, 8'd16);
        add_vec(416, 1'b1, 8'd31);
        check_vecs("wrap");

        // overlapping sprites, transparent hole in the higher-priority one
        write_entry(0, 1'b0, 0, 0, 0, 0, 1'b0);
        write_entry(1, 1'b1, 300, 120, 0, 16, 1'b0);
        write_entry(3, 1'b1, 300, 120, 32, 0, 1'b0);
        rom_mem[869] = 8'hFF;
        run_line(121);
        run_line(122);
        for (int col = 0; col < 16; col++) exp_q.push_back((col == 5) ? 9'h185 : {1'b1, 8'(8'h60 + col)});
        for (int col = 0; col < 16; col++) begin
            e = exp_q[0][7:0];
            check($sformatf("t3 col%0d hit", col), 32'(cap_hit[301 + col]), 32'(exp_q[0][8]));
            check($sformatf("t3 col%0d rgb", col), 32'(cap_rgb[301 + col]), 32'(e));
            void'(exp_q.pop_front());
        end
        add_vec(300, 1'b0, 8'h00);
        add_vec(317, 1'b0, 8'h00);
        check_vecs("t3");
        rom_mem[869] = 8'h65;

        // six visible sprites: four slots on the main instance, budget overrun on the late one
        for (int i = 0; i < 6; i++) write_entry(i, 1'b1, 20 + 40 * i, 50, 0, 0, 1'b0);
        ovf0 = ovf_cnt; late0 = late_cnt; late20 = late2_cnt; busy0 = busy_cnt;
        run_line(49);
        check("t2 ovf pulses", 32'(ovf_cnt - ovf0), 1);
        check("t2 busy in budget", 32'((busy_cnt - busy0 > 0) && (busy_cnt - busy0 <= 76)), 1);
        check("t5 late pulses", 32'(late2_cnt - late20), 1);
        check("t5 late hcount", 32'(late2_h), 799);
        run_line(50);
        for (int i = 0; i < 6; i++) begin
            add_vec(20 + 40 * i + 1, (i < 4), 8'h00);
            add_vec(20 + 40 * i + 8, (i < 4), (i < 4) ? 8'd7 : 8'd0);
            add_vec(20 + 40 * i + 16, (i < 4), (i < 4) ? 8'd15 : 8'd0);
        end
        check_vecs("t2");
        check("t2 hit count", 32'(count_hits(0)), 64);
        check("t5 no hits after late", 32'(count_hits(1)), 0);

        // reset in the middle of a fetch
        @(negedge clk);
        bus.vcount = 10'd51; bus.hcount = 10'd0; bus.pix_en = 1'b1;
        @(negedge clk);
        bus.pix_en = 1'b0;
        repeat (3) @(negedge clk);
        bus.hcount = 10'd25; bus.pix_en = 1'b1;
        @(negedge clk);
        bus.pix_en = 1'b0;
        check("t4 pre hit", 32'(bus.spr_hit), 1);
        check("t4 pre rgb", 32'(bus.spr_rgb), 32'h34);
        repeat (5) @(negedge clk);
        check("t4 pre state fetch", 32'(bus.dbg_state), 2);
        check("t4 pre busy", 32'(bus.busy), 1);
        check("t4 pre rom_addr active", 32'(bus.rom_addr != '0), 1);
        #2 rst = 1'b1;
        #1;
        check("t4 busy", 32'(bus.busy), 0);
        check("t4 hit", 32'(bus.spr_hit), 0);
        check("t4 rgb", 32'(bus.spr_rgb), 0);
        check("t4 rom_addr", 32'(bus.rom_addr), 0);
        check("t4 state", 32'(bus.dbg_state), 0);
        @(negedge clk);
        rst = 1'b0;
        write_entry(0, 1'b1, 20, 50, 0, 0, 1'b0);
        run_line(52);
        check("t4 line52 empty", 32'(count_hits(0)), 0);
        run_line(53);
        add_vec(20, 1'b0, 8'h00);
        add_vec(21, 1'b1, 8'h90);
        add_vec(36, 1'b1, 8'h9F);
        add_vec(37, 1'b0, 8'h00);
        check_vecs("t4 line53");

        check("main never late", 32'(late_cnt), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
